// File: rtl/cmos_capture_rgb565_if.sv
// Byte-stream input and pixel-rate frame output of the CMOS RGB565 capture block.
// master = sensor/consumer side, slave = the capture block.
interface cmos_capture_rgb565_if;
   logic        cmos_vsync;
   logic        cmos_href;
   logic [7:0]  cmos_data;
   logic        cmos_frame_vsync;
   logic        cmos_frame_href;
   logic        cmos_frame_clken;
   logic [15:0] cmos_frame_data;
   logic        cmos_frame_done;
   logic        cmos_line_err;
   logic        cmos_frame_err;

   modport master (
      output cmos_vsync, cmos_href, cmos_data,
      input  cmos_frame_vsync, cmos_frame_href, cmos_frame_clken, cmos_frame_data,
      input  cmos_frame_done, cmos_line_err, cmos_frame_err
   );

   modport slave (
      input  cmos_vsync, cmos_href, cmos_data,
      output cmos_frame_vsync, cmos_frame_href, cmos_frame_clken, cmos_frame_data,
      output cmos_frame_done, cmos_line_err, cmos_frame_err
   );
endinterface

// File: rtl/cmos_capture_rgb565.sv
// CMOS byte stream -> gated RGB565 pixel stream, 2-cycle latency, warm-up frame drop.
// Define CMOS_FRAME_STAT_EN to build the x/y counters, line/frame errors and frame_done.
module cmos_capture_rgb565 #(
   parameter logic        CMOS_VSYNC_VALID   = 1'b1,
   parameter logic [3:0]  CMOS_FRAME_WAITCNT = 4'd10,
   parameter logic [10:0] IMG_HDISP          = 11'd640,
   parameter logic [10:0] IMG_VDISP          = 11'd480
) (
   input logic                   cmos_pclk,
   input logic                   rst_n,
   cmos_capture_rgb565_if.slave  cam
);

   logic        fa_q, fa_qq, href_q;
   logic [7:0]  byte_q, hold_q, hold_d;
   logic        flag_q, flag_d;
   logic [3:0]  wait_q, wait_d;
   logic        en_q, en_d;
   logic        start, pix_ev;
   logic        s2_vs_q, s2_hr_q, s2_ck_q;
   logic [15:0] s2_px_q;
   logic        vs_q, hr_q, ck_q;
   logic [15:0] px_q;

   always_comb begin
      start  = fa_q & ~fa_qq;
      pix_ev = href_q & flag_q;
      en_d   = en_q | (start & (wait_q == CMOS_FRAME_WAITCNT));
      wait_d = wait_q;
      if (start && !en_q) wait_d = wait_q + 4'd1;
      flag_d = href_q ? ~flag_q : 1'b0;
      hold_d = (href_q && !flag_q) ? byte_q : hold_q;
   end

   // fa history resets to "active" so a frame running at reset release is never seen as started
   always_ff @(posedge cmos_pclk) begin
      if (!rst_n) begin
         fa_q    <= 1'b1;
         fa_qq   <= 1'b1;
         href_q  <= 1'b0;
         byte_q  <= '0;
         flag_q  <= 1'b0;
         hold_q  <= '0;
         wait_q  <= '0;
         en_q    <= 1'b0;
         s2_vs_q <= 1'b0;
         s2_hr_q <= 1'b0;
         s2_ck_q <= 1'b0;
         s2_px_q <= '0;
         vs_q    <= 1'b0;
         hr_q    <= 1'b0;
         ck_q    <= 1'b0;
         px_q    <= '0;
      end else begin
         fa_q    <= (cam.cmos_vsync == CMOS_VSYNC_VALID);
         fa_qq   <= fa_q;
         href_q  <= cam.cmos_href;
         byte_q  <= cam.cmos_data;
         flag_q  <= flag_d;
         hold_q  <= hold_d;
         wait_q  <= wait_d;
         en_q    <= en_d;
         s2_vs_q <= fa_q & en_d;
         s2_hr_q <= href_q & fa_q & en_d;
         s2_ck_q <= pix_ev & fa_q & en_d;
         s2_px_q <= {hold_q, byte_q};
         vs_q    <= s2_vs_q;
         hr_q    <= s2_hr_q;
         ck_q    <= s2_ck_q;
         if (s2_ck_q) px_q <= s2_px_q;
      end
   end

   assign cam.cmos_frame_vsync = vs_q;
   assign cam.cmos_frame_href  = hr_q;
   assign cam.cmos_frame_clken = ck_q;
   assign cam.cmos_frame_data  = px_q;

`ifdef CMOS_FRAME_STAT_EN
   logic        href_qq, fin, hfall_any, hfall;
   logic [10:0] x_q, x_d, y_q, y_d;
   logic        lerr_q, lerr_d, ferr_q, ferr_d, s2_dn_q, dn_q;

   // any href fall resets x so a line cut by frame end cannot leak into the next frame
   always_comb begin
      fin       = ~fa_q & fa_qq;
      hfall_any = ~href_q & href_qq;
      hfall     = hfall_any & fa_qq;
      x_d       = x_q;
      y_d       = y_q;
      lerr_d    = lerr_q;
      ferr_d    = ferr_q;
      if (start) begin
         x_d = '0;
         y_d = '0;
      end
      if (pix_ev && fa_q && x_d != '1) x_d = x_d + 11'd1;
      if (hfall_any) begin
         if (hfall) begin
            if (en_q && (x_q != IMG_HDISP || flag_q)) lerr_d = 1'b1;
            if (y_d != '1) y_d = y_d + 11'd1;
         end
         x_d = '0;
      end
      if (fin) begin
         if (en_q && y_d != IMG_VDISP) ferr_d = 1'b1;
         y_d = '0;
      end
   end

   always_ff @(posedge cmos_pclk) begin
      if (!rst_n) begin
         href_qq <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         lerr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         s2_dn_q <= 1'b0;
         dn_q    <= 1'b0;
      end else begin
         href_qq <= href_q;
         x_q     <= x_d;
         y_q     <= y_d;
         lerr_q  <= lerr_d;
         ferr_q  <= ferr_d;
         s2_dn_q <= fin & en_q;
         dn_q    <= s2_dn_q;
      end
   end

   assign cam.cmos_frame_done = dn_q;
   assign cam.cmos_line_err   = lerr_q;
   assign cam.cmos_frame_err  = ferr_q;
`else
   assign cam.cmos_frame_done = 1'b0;
   assign cam.cmos_line_err   = 1'b0;
   assign cam.cmos_frame_err  = 1'b0;
`endif

endmodule

// File: doc/cmos_capture_rgb565.md
Name: cmos_capture_rgb565

Overview:
Downstream of the CMOS source/sensor model; sits on the pixel clock and consumes the 8-bit byte stream (vsync/href/data).
Discards the first CMOS_FRAME_WAITCNT frames after reset, then pairs bytes into RGB565 pixels.
Emits a gated, pixel-rate frame interface (vsync/href/clken/data) with a 2-cycle fixed latency for the downstream VIP pipeline.

Parameters:
CMOS_VSYNC_VALID, 1'b1, cmos_vsync level meaning "frame active" (1: high = active; 0: low = active)
CMOS_FRAME_WAITCNT, 4'd10, number of complete frames dropped after reset (0 = output first frame)
IMG_HDISP, 11'd640, expected pixels per line (bytes per line = 2*IMG_HDISP)
IMG_VDISP, 11'd480, expected lines per frame

Ports:
cmos_pclk  input  1  pixel clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
cmos_vsync  input  1  frame sync, polarity per CMOS_VSYNC_VALID
cmos_href  input  1  byte valid, high = valid
cmos_data  input  8  byte data
cmos_frame_vsync  output  1  frame active (active-high), gated, delayed
cmos_frame_href  output  1  line active, gated, delayed
cmos_frame_clken  output  1  one-cycle pixel strobe
cmos_frame_data  output  16  RGB565 pixel, valid when clken=1
cmos_frame_done  output  1  one-cycle pulse at end of each output frame
cmos_line_err  output  1  sticky: output line with pixel count != IMG_HDISP, or odd byte count
cmos_frame_err  output  1  sticky: output frame with line count != IMG_VDISP

Behaviour:
- Reset is synchronous: on rising cmos_pclk with rst_n=0, all outputs go to 0 and the frame counter to 0. The delayed copy of frame-active resets to 1 (active), so a frame already in progress at reset release is never counted or output.
- Input stage: vsync/href/data registered once. fa = (cmos_vsync == CMOS_VSYNC_VALID).
- Frame edges:
  - frame start = registered fa rising.
  - frame end = registered fa falling.
- Warm-up: wait_cnt (4 bits) increments at each frame start while out_en=0.
  - out_en is set at a frame start where the pre-increment wait_cnt == CMOS_FRAME_WAITCNT; that frame is the first one output.
  - out_en stays 1 until reset and never toggles mid-frame.
- Byte pairing while registered href=1:
  - byte_flag toggles each cycle.
  - first byte is held as [15:8], second byte gives [7:0].
  - on the second byte: cmos_frame_data = {held, byte}, cmos_frame_clken = 1 for one cycle.
  - byte_flag clears when href=0.
  - a dangling odd byte at href fall is dropped, and cmos_line_err is set when out_en=1.
- Latency: second byte on cmos_data at edge N → clken/data valid after edge N+2. cmos_frame_vsync/href are fa/href delayed 2 cycles and ANDed with out_en.
- Data hold: when clken=0, cmos_frame_data holds its last value. It is reset to 0.
- Pixel counter x (11 bits):
  - increments per clken.
  - at href fall: if x != IMG_HDISP, line_err is set (when out_en); x then clears.
- Line counter y (11 bits):
  - increments at each href fall.
  - at frame end: if out_en and y != IMG_VDISP, cmos_frame_err is set; cmos_frame_done pulses one cycle (aligned with cmos_frame_vsync fall); y then clears.
  - y also clears at frame start.
- Counter saturation: x and y saturate at 11'h7FF, with no wrap.
- Errors: cleared only by reset.
- href while frame inactive: bytes are still paired, but every output stays 0 because the gated vsync is low; the counters ignore them.
- Frame start and href rising in the same cycle: the start is processed first, and the byte counts toward the new frame.

Optional Feature:
CMOS_FRAME_STAT_EN
- defined: x/y counters, cmos_line_err, cmos_frame_err and cmos_frame_done are implemented as above.
- undefined: the counters are removed; cmos_line_err, cmos_frame_err and cmos_frame_done are tied to 0. Pairing, gating and latency are unchanged.

Test Plan:
- WAITCNT=2, HDISP=4, VDISP=3; 5 clean frames → vsync/href out only for frames 2,3,4. 12 clken per output frame, 3 frame_done pulses, both errs 0.
- Bytes 8'hF8,8'h1F,8'h07,8'hE0 in one line → data 16'hF81F then 16'h07E0. Each clken comes exactly 2 cycles after its second byte.
- rst_n released while fa=1 mid-frame, WAITCNT=0 → no output for the partial frame; the next full frame is output.
- WAITCNT=0, a line of 7 bytes → 3 pixels; dangling byte dropped; cmos_line_err=1 and stays 1 through later clean frames.
- WAITCNT=0, frame with 2 lines (VDISP=3) → frame_done pulses and cmos_frame_err=1. Same with CMOS_VSYNC_VALID=0 and inverted vsync → identical output.
- Macro undefined, same error stimulus → errs and frame_done remain 0; pixel data/clken are identical to the macro-defined run.
